pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: stalls, flushes, freezes, EX forwarding.
// Optional performance counters are enabled with `define HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [4:0] id_Rn,
   input  logic [4:0] id_Rm,
   input  logic       id_useRn,
   input  logic       id_useRm,
   input  logic [4:0] id_Rd,
   input  logic       id_RegWrite,
   input  logic       id_MemRead,
   input  logic       id_flagWrite,
   input  logic       id_flagRead,
   input  logic       ex_br_taken,
   input  logic       mem_busy,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       ifid_flush,
   output logic       idex_en,
   output logic       idex_bubble,
   output logic       exmem_en,
   output logic       memwb_en,
   output logic [1:0] fwdA,
   output logic [1:0] fwdB,
   output logic       mem_err
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
`endif
);

   localparam logic [4:0]  ZeroReg = 5'd31;
   localparam int unsigned TW      = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef struct packed {
      logic       valid;
      logic [4:0] rn;
      logic [4:0] rm;
      logic       use_rn;
      logic       use_rm;
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
      logic       flag_write;
   } slot_t;

   typedef enum logic [0:0] {StRun, StFreeze} state_e;

   state_e        state_q, state_d;
   slot_t         ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          mem_err_q, mem_err_d;
   logic          load_use, flag_haz, br_flush;
   logic          do_stall, do_flush;

   function automatic logic [1:0] fwd_sel(input logic [4:0] r, input slot_t m, input slot_t w);
      if (m.valid && m.reg_write && !m.mem_read && m.rd != ZeroReg && m.rd == r) begin
         return 2'b01;
      end else if (w.valid && w.reg_write && w.rd != ZeroReg && w.rd == r) begin
         return 2'b10;
      end
      return 2'b00;
   endfunction

   always_comb begin
      load_use = id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
                 ex_q.rd != ZeroReg &&
                 ((id_useRn && id_Rn == ex_q.rd) || (id_useRm && id_Rm == ex_q.rd));
      flag_haz = id_valid && id_flagRead && ex_q.valid && ex_q.flag_write;
      br_flush = ex_br_taken && ex_q.valid;

      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_bubble = 1'b0;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      do_stall    = 1'b0;
      do_flush    = 1'b0;
      // Freeze applies from the first busy cycle; reset forces the idle output values.
      if (!reset) begin
         if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
         end else if (br_flush) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            do_flush    = 1'b1;
         end else if (load_use || flag_haz) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            do_stall    = 1'b1;
         end
      end

      fwdA = fwd_sel(ex_q.rn, mem_q, wb_q);
      fwdB = fwd_sel(ex_q.rm, mem_q, wb_q);
   end

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (idex_en) begin
         ex_d = '{valid: id_valid && !idex_bubble, rn: id_Rn, rm: id_Rm, use_rn: id_useRn,
                  use_rm: id_useRm, rd: id_Rd, reg_write: id_RegWrite, mem_read: id_MemRead,
                  flag_write: id_flagWrite};
      end
      if (exmem_en) mem_d = ex_q;
      if (memwb_en) wb_d = mem_q;

      state_d   = mem_busy ? StFreeze : StRun;
      tmo_cnt_d = '0;
      // The first busy cycle is spent in RUN; counting covers the cycles spent in FREEZE.
      if (mem_busy && state_q == StFreeze) begin
         tmo_cnt_d = (tmo_cnt_q == TW'(MEM_TIMEOUT)) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
      end
      mem_err_d = mem_err_q || (tmo_cnt_d == TW'(MEM_TIMEOUT));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StRun;
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         tmo_cnt_q <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ex_q      <= ex_d;
         mem_q     <= mem_d;
         wb_q      <= wb_d;
         tmo_cnt_q <= tmo_cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

   // Fields kept for a complete shadow record but not needed by the hazard checks.
   logic unused_slot;
   assign unused_slot = ^{ex_q.use_rn, ex_q.use_rm, mem_q.rn, mem_q.rm, mem_q.use_rn,
                          mem_q.use_rm, mem_q.flag_write, wb_q.rn, wb_q.rm, wb_q.use_rn,
                          wb_q.use_rm, wb_q.mem_read, wb_q.flag_write};

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if ((do_stall || (mem_busy && !reset)) && stall_q != '1) stall_d = stall_q + 1'b1;
      if (do_flush && flush_q != '1) flush_d = flush_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   logic unused_perf;
   assign unused_perf = ^{do_stall, do_flush};
`endif

endmodule
